// File: rtl/deinterleave_pkg.sv
`default_nettype none
// ============================================================================
// deinterleave_pkg : shared mode type and address/width helpers
// Rev 1.0
// ============================================================================
package deinterleave_pkg;

  typedef enum logic {
    DEINT = 1'b0,
    INT   = 1'b1
  } mode_e;

  function automatic int cnt_w(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

  // DEINT reads interleaved storage channel-major; INT reads channel-major storage interleaved.
  function automatic int perm_addr(input int c, input int n, input int iir, input int nn,
                                   input int mode);
    return (mode == int'(INT)) ? (c * nn + n) : (n * iir + c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/deinterleave_rd_addr_gen.sv
`default_nettype none
// ============================================================================
// deinterleave_rd_addr_gen : nested channel/sample read counters and address
// Rev 1.0
// ============================================================================
module deinterleave_rd_addr_gen
  import deinterleave_pkg::*;
#(
  parameter int IIR  = 3,
  parameter int N    = 10,
  parameter int MODE = 0,
  parameter int AW   = cnt_w(IIR * N),
  parameter int CW   = cnt_w(IIR)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear_i,
  input  logic          advance_i,
  output logic [AW-1:0] addr_o,
  output logic [CW-1:0] chan_o,
  output logic          last_o
);

  localparam int NW = cnt_w(N);

  logic [CW-1:0] rd_c_q, rd_c_d;
  logic [NW-1:0] rd_n_q, rd_n_d;
  logic          c_wrap;
  logic          n_wrap;

  assign c_wrap = (rd_c_q == CW'(IIR - 1));
  assign n_wrap = (rd_n_q == NW'(N - 1));

  // Channel counter is the inner loop when interleaving, the outer loop otherwise.
  always_comb begin
    rd_c_d = rd_c_q;
    rd_n_d = rd_n_q;
    if (clear_i) begin
      rd_c_d = '0;
      rd_n_d = '0;
    end else if (advance_i) begin
      if (MODE == int'(INT)) begin
        if (c_wrap) begin
          rd_c_d = '0;
          rd_n_d = n_wrap ? '0 : rd_n_q + 1'b1;
        end else begin
          rd_c_d = rd_c_q + 1'b1;
        end
      end else begin
        if (n_wrap) begin
          rd_n_d = '0;
          rd_c_d = c_wrap ? '0 : rd_c_q + 1'b1;
        end else begin
          rd_n_d = rd_n_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_c_q <= '0;
      rd_n_q <= '0;
    end else begin
      rd_c_q <= rd_c_d;
      rd_n_q <= rd_n_d;
    end
  end

  assign addr_o = AW'(perm_addr(int'(rd_c_q), int'(rd_n_q), IIR, N, MODE));
  assign chan_o = rd_c_q;
  assign last_o = c_wrap && n_wrap;

endmodule
`default_nettype wire

// File: rtl/deinterleave_block_pingpong_vector.sv
`default_nettype none
// ============================================================================
// deinterleave_block_pingpong_vector : V-lane block (de)interleaver, ping-pong banks
// Rev 1.0
// ============================================================================
module deinterleave_block_pingpong_vector
  import deinterleave_pkg::*;
#(
  parameter int BITS = 8,
  parameter int IIR  = 3,
  parameter int N    = 10,
  parameter int V    = 2,
  parameter int MODE = 0,
  localparam int CW  = cnt_w(IIR)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_last,
  input  logic [BITS-1:0] data_in [V],
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] data_out [V],
  output logic [CW-1:0]   out_chan,
  output logic            out_last,
  output logic            frame_err
);

  localparam int L  = IIR * N;
  localparam int AW = cnt_w(L);
  localparam int DW = V * BITS;

  logic [DW-1:0] mem_q [2][L];

  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [1:0]    full_q, full_d;
  logic          out_valid_q;
  logic          out_last_q;
  logic [CW-1:0] out_chan_q;
  logic [DW-1:0] dout_q;
  logic          frame_err_q;

  logic [DW-1:0] din_w;
  logic [DW-1:0] rd_word;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] rd_chan;
  logic          rd_last;
  logic          accept;
  logic          load;
  logic          wr_last;

  for (genvar g = 0; g < V; g++) begin : g_lane
    assign din_w[g*BITS +: BITS] = data_in[g];
    assign data_out[g]           = dout_q[g*BITS +: BITS];
  end

  assign in_ready = !full_q[wr_bank_q] && !flush;
  assign accept   = in_valid && in_ready;
  assign wr_last  = (wr_cnt_q == AW'(L - 1));
  assign load     = full_q[rd_bank_q] && (!out_valid_q || out_ready) && !flush;

  deinterleave_rd_addr_gen #(
    .IIR  (IIR),
    .N    (N),
    .MODE (MODE),
    .AW   (AW),
    .CW   (CW)
  ) u_rd_addr (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (flush),
    .advance_i (load),
    .addr_o    (rd_addr),
    .chan_o    (rd_chan),
    .last_o    (rd_last)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_bank_q][wr_cnt_q] <= din_w;
    end
  end

  assign rd_word = mem_q[rd_bank_q][rd_addr];

  // Writer only ever sets a non-full bank and the reader only clears a full one,
  // so both updates can land on the same edge without conflict.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    if (accept) begin
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
    if (load && rd_last) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_chan_q  <= '0;
      dout_q      <= '0;
      frame_err_q <= 1'b0;
    end else if (flush) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_chan_q  <= '0;
      dout_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      // in_last is advisory: a mismatch is flagged but never resynchronises wr_cnt.
      frame_err_q <= accept && (in_last != wr_last);
      if (load) begin
        out_valid_q <= 1'b1;
        dout_q      <= rd_word;
        out_chan_q  <= rd_chan;
        out_last_q  <= rd_last;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_chan  = out_chan_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire
